// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the cache-port arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      REQ_IFETCH = 2'd0,
      REQ_DREAD  = 2'd1,
      REQ_DWRITE = 2'd2
   } req_id_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      ACK   = 3'd2,
      BUSY  = 3'd3,
      RESP  = 3'd4
   } arb_state_t;

   localparam logic [3:0] IFETCH_SIZE = 4'd4;

   function automatic req_id_t next_id(input req_id_t id);
      case (id)
         REQ_IFETCH: return REQ_DREAD;
         REQ_DREAD:  return REQ_DWRITE;
         default:    return REQ_IFETCH;
      endcase
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick3.sv
// rtl/mem_arbiter_rr_pick3.sv - combinational 3-way round-robin picker
module rr_pick3
   import mem_arb_pkg::*;
(
   input  logic [2:0] req,
   input  req_id_t    ptr,
   output req_id_t    grant,
   output logic       valid
);

   // req bit order: [0]=fetch, [1]=data read, [2]=data write; search starts at ptr
   always_comb begin
      valid = |req;
      grant = REQ_IFETCH;
      case (ptr)
         REQ_IFETCH: begin
            if (req[0])      grant = REQ_IFETCH;
            else if (req[1]) grant = REQ_DREAD;
            else if (req[2]) grant = REQ_DWRITE;
         end
         REQ_DREAD: begin
            if (req[1])      grant = REQ_DREAD;
            else if (req[2]) grant = REQ_DWRITE;
            else if (req[0]) grant = REQ_IFETCH;
         end
         default: begin
            if (req[2])      grant = REQ_DWRITE;
            else if (req[0]) grant = REQ_IFETCH;
            else if (req[1]) grant = REQ_DREAD;
         end
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the single cache port between fetch, data read and data write
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 64,
   parameter int DATA_WIDTH  = 64,
   parameter int ACK_TIMEOUT = 8
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_done,
   output logic [DATA_WIDTH-1:0] i_rdata,

   input  logic                  dr_req,
   input  logic [ADDR_WIDTH-1:0] dr_addr,
   input  logic [3:0]            dr_size,
   output logic                  dr_done,
   output logic [DATA_WIDTH-1:0] dr_rdata,

   input  logic                  dw_req,
   input  logic [ADDR_WIDTH-1:0] dw_addr,
   input  logic [3:0]            dw_size,
   input  logic [DATA_WIDTH-1:0] dw_wdata,
   output logic                  dw_done,

   output logic                  c_instruction_read,
   output logic                  c_mem_read,
   output logic                  c_mem_write,
   output logic [ADDR_WIDTH-1:0] c_addr,
   output logic [3:0]            c_size,
   output logic [DATA_WIDTH-1:0] c_wdata,
   input  logic                  c_busy,
   input  logic [DATA_WIDTH-1:0] c_rdata,

   output logic                  timeout
);

   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

   arb_state_t       state;
   req_id_t          ptr;
   req_id_t          winner;
   req_id_t          pick;
   logic             pick_valid;
   logic [CNT_W-1:0] ack_cnt;
   logic             ack_expired;
   logic             finish;

   rr_pick3 u_pick (
      .req   ({dw_req, dr_req, i_req}),
      .ptr   (ptr),
      .grant (pick),
      .valid (pick_valid)
   );

   // A cache that never raises busy still completes once the ACK window runs out
   assign ack_expired = (state == ACK) && !c_busy && (ack_cnt == CNT_W'(ACK_TIMEOUT));
   assign finish      = ack_expired || ((state == BUSY) && !c_busy);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state              <= IDLE;
         ptr                <= REQ_IFETCH;
         winner             <= REQ_IFETCH;
         ack_cnt            <= '0;
         i_done             <= 1'b0;
         i_rdata            <= '0;
         dr_done            <= 1'b0;
         dr_rdata           <= '0;
         dw_done            <= 1'b0;
         c_instruction_read <= 1'b0;
         c_mem_read         <= 1'b0;
         c_mem_write        <= 1'b0;
         c_addr             <= '0;
         c_size             <= '0;
         c_wdata            <= '0;
         timeout            <= 1'b0;
      end else begin
         i_done             <= 1'b0;
         dr_done            <= 1'b0;
         dw_done            <= 1'b0;
         timeout            <= 1'b0;
         c_instruction_read <= 1'b0;
         c_mem_read         <= 1'b0;
         c_mem_write        <= 1'b0;

         case (state)
            IDLE: begin
               if (pick_valid && !c_busy) begin
                  winner <= pick;
                  state  <= ISSUE;
                  case (pick)
                     REQ_IFETCH: begin
                        c_addr             <= i_addr;
                        c_size             <= IFETCH_SIZE;
                        c_wdata            <= '0;
                        c_instruction_read <= 1'b1;
                     end
                     REQ_DREAD: begin
                        c_addr     <= dr_addr;
                        c_size     <= dr_size;
                        c_wdata    <= '0;
                        c_mem_read <= 1'b1;
                     end
                     default: begin
                        c_addr      <= dw_addr;
                        c_size      <= dw_size;
                        c_wdata     <= dw_wdata;
                        c_mem_write <= 1'b1;
                     end
                  endcase
               end
            end

            ISSUE: begin
               ack_cnt <= '0;
               state   <= ACK;
            end

            ACK: begin
               if (c_busy)
                  state <= BUSY;
               else if (!ack_expired)
                  ack_cnt <= ack_cnt + CNT_W'(1);
            end

            RESP: begin
               ptr   <= next_id(winner);
               state <= IDLE;
            end

            default: ;
         endcase

         if (finish) begin
            state   <= RESP;
            timeout <= ack_expired;
            case (winner)
               REQ_IFETCH: begin
                  i_done  <= 1'b1;
                  i_rdata <= c_rdata;
               end
               REQ_DREAD: begin
                  dr_done  <= 1'b1;
                  dr_rdata <= c_rdata;
               end
               default: dw_done <= 1'b1;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, dr_req, dw_req;
   logic [63:0] i_addr, dr_addr, dw_addr, dw_wdata;
   logic [3:0]  dr_size, dw_size;
   logic        c_busy;
   logic [63:0] c_rdata;

   logic        i_done, dr_done, dw_done, timeout;
   logic [63:0] i_rdata, dr_rdata, c_addr, c_wdata;
   logic [3:0]  c_size;
   logic        c_instruction_read, c_mem_read, c_mem_write;

   logic [2:0]  strobes, dones;
   assign strobes = {c_mem_write, c_mem_read, c_instruction_read};
   assign dones   = {dw_done, dr_done, i_done};

   int checks = 0;
   int errors = 0;
   int n_i = 0, n_dr = 0, n_dw = 0, n_multi = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .ACK_TIMEOUT(8)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
      .dr_req(dr_req), .dr_addr(dr_addr), .dr_size(dr_size), .dr_done(dr_done), .dr_rdata(dr_rdata),
      .dw_req(dw_req), .dw_addr(dw_addr), .dw_size(dw_size), .dw_wdata(dw_wdata), .dw_done(dw_done),
      .c_instruction_read(c_instruction_read), .c_mem_read(c_mem_read), .c_mem_write(c_mem_write),
      .c_addr(c_addr), .c_size(c_size), .c_wdata(c_wdata), .c_busy(c_busy), .c_rdata(c_rdata),
      .timeout(timeout)
   );

   always @(negedge clk) begin
      if (i_done)  n_i++;
      if (dr_done) n_dr++;
      if (dw_done) n_dw++;
      if ($countones(strobes) > 1) n_multi++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic zero_check(input string tag);
      chk({tag, "_strobes"}, 64'(strobes), 64'd0);
      chk({tag, "_dones"},   64'({dones, timeout}), 64'd0);
      chk({tag, "_addr"},    c_addr, 64'd0);
      chk({tag, "_size"},    64'(c_size), 64'd0);
      chk({tag, "_wdata"},   c_wdata, 64'd0);
      chk({tag, "_i_rdata"}, i_rdata, 64'd0);
      chk({tag, "_dr_rdata"}, dr_rdata, 64'd0);
   endtask

   logic [2:0]  exp_grant [4];
   logic [63:0] exp_addr  [4];

   initial begin
      reset = 1'b0;
      i_req = 0; dr_req = 0; dw_req = 0;
      i_addr = 0; dr_addr = 0; dw_addr = 0; dw_wdata = 0;
      dr_size = 0; dw_size = 0; c_busy = 0; c_rdata = 0;
      exp_grant[0] = 3'b001; exp_grant[1] = 3'b010; exp_grant[2] = 3'b100; exp_grant[3] = 3'b001;
      exp_addr[0] = 64'h1000; exp_addr[1] = 64'h3000; exp_addr[2] = 64'h2008; exp_addr[3] = 64'h1000;

      tick(); tick();
      zero_check("reset");
      reset = 1'b1;
      tick();

      // single fetch, cache busy cycles 2-4
      i_req = 1; i_addr = 64'h1000;
      tick();
      chk("fetch_strobe", 64'(strobes), 64'b001);
      chk("fetch_addr", c_addr, 64'h1000);
      chk("fetch_size", 64'(c_size), 64'd4);
      tick(); c_busy = 1;
      chk("fetch_strobe_one_cycle", 64'(strobes), 64'd0);
      tick(); tick();
      tick(); c_busy = 0; c_rdata = 64'h13;
      chk("fetch_done_not_early", 64'(dones), 64'd0);
      tick();
      chk("fetch_done", 64'(dones), 64'b001);
      chk("fetch_rdata", i_rdata, 64'h13);
      i_req = 0;
      tick();
      chk("fetch_done_one_cycle", 64'(dones), 64'd0);
      chk("fetch_rdata_hold", i_rdata, 64'h13);

      // write, minimum latency
      dw_req = 1; dw_addr = 64'h2008; dw_wdata = 64'hDEADBEEF; dw_size = 4'd8;
      tick();
      chk("wr_strobe", 64'(strobes), 64'b100);
      chk("wr_addr", c_addr, 64'h2008);
      chk("wr_size", 64'(c_size), 64'd8);
      chk("wr_wdata", c_wdata, 64'hDEADBEEF);
      tick(); c_busy = 1;
      tick(); c_busy = 0; c_rdata = 64'h55;
      tick();
      chk("wr_done", 64'(dones), 64'b100);
      chk("wr_addr_stable", c_addr, 64'h2008);
      chk("wr_wdata_stable", c_wdata, 64'hDEADBEEF);
      chk("wr_no_read_capture", dr_rdata, 64'd0);
      chk("wr_strobes_idle", 64'(strobes), 64'd0);
      dw_req = 0;
      tick();

      // data read with a cache that never raises busy
      dr_req = 1; dr_addr = 64'h3000; dr_size = 4'd2; c_rdata = 64'hABCD;
      tick();
      chk("to_strobe", 64'(strobes), 64'b010);
      chk("to_wdata_zero", c_wdata, 64'd0);
      chk("to_size", 64'(c_size), 64'd2);
      repeat (9) tick();
      chk("to_not_early", 64'({timeout, dr_done}), 64'd0);
      tick();
      chk("to_pulse", 64'({timeout, dr_done}), 64'b11);
      chk("to_rdata", dr_rdata, 64'hABCD);
      dr_req = 0;
      tick();
      chk("to_pulse_one_cycle", 64'(timeout), 64'd0);

      // busy cache in IDLE blocks the grant
      c_busy = 1; dr_req = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("busy_blocks", 64'(strobes), 64'd0);
      end
      c_busy = 0;
      tick();
      chk("busy_release_strobe", 64'(strobes), 64'b010);
      tick(); c_busy = 1;
      tick(); c_busy = 0; c_rdata = 64'h77;
      tick();
      chk("busy_release_done", 64'(dones), 64'b010);
      chk("busy_release_rdata", dr_rdata, 64'h77);
      dr_req = 0;
      tick();

      // reset while the write sits in BUSY
      dw_req = 1;
      tick();
      chk("abort_strobe", 64'(strobes), 64'b100);
      tick(); c_busy = 1;
      tick();
      #2 reset = 1'b0;
      #1 zero_check("async_reset");
      dw_req = 0;
      tick();
      chk("abort_no_done_a", 64'(dones), 64'd0);
      tick();
      chk("abort_no_done_b", 64'(dones), 64'd0);
      reset = 1'b1; c_busy = 0;
      i_req = 1; dr_req = 1; dw_req = 1;

      // all three pending from a fresh pointer
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rr_grant", 64'(strobes), 64'(exp_grant[k]));
         chk("rr_addr", c_addr, exp_addr[k]);
         tick(); c_busy = 1;
         tick(); c_busy = 0; c_rdata = 64'h100 + 64'(k);
         tick();
         chk("rr_done", 64'(dones), 64'(exp_grant[k]));
         if (k == 0) chk("rr_i_rdata0", i_rdata, 64'h100);
         if (k == 1) chk("rr_dr_rdata1", dr_rdata, 64'h101);
         if (k == 3) chk("rr_i_rdata3", i_rdata, 64'h103);
         tick();
         chk("rr_done_one_cycle", 64'(dones), 64'd0);
      end
      i_req = 0; dr_req = 0; dw_req = 0;
      tick(); tick();

      chk("count_i_done", 64'(n_i), 64'd3);
      chk("count_dr_done", 64'(n_dr), 64'd3);
      chk("count_dw_done", 64'(n_dw), 64'd2);
      chk("strobe_onehot", 64'(n_multi), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter that shares the single cache port between three requesters: instruction fetch, data read and data write. It sits between the pipeline front/back ends and `cache`. It owns the one-hot `instruction_read`/`mem_read`/`mem_write` command strobes, latches address, data and size for the granted requester, tracks completion via the cache's `busy`, and returns a one-cycle `done` with read data to the winner. Arbitration is 3-way round-robin.

## Interface
- `ADDR_WIDTH`, 64, request address width
- `DATA_WIDTH`, 64, read/write data width
- `ACK_TIMEOUT`, 8, cycles to wait in ACK for `c_busy` to rise before treating the access as complete
- `clk  input  1  sole clock, rising edge`
- `reset  input  1  asynchronous, active-low (asserted at 0), synchronous deassertion assumed upstream`
- `i_req  input  1  fetch request, held until i_done`
- `i_addr  input  ADDR_WIDTH  fetch address`
- `i_done  output  1  one-cycle completion pulse`
- `i_rdata  output  DATA_WIDTH  fetch data, valid with i_done`
- `dr_req / dr_addr / dr_size  input  1 / ADDR_WIDTH / 4  data read request, address, byte size`
- `dr_done / dr_rdata  output  1 / DATA_WIDTH  completion pulse, data`
- `dw_req / dw_addr / dw_size / dw_wdata  input  1 / ADDR_WIDTH / 4 / DATA_WIDTH  data write request`
- `dw_done  output  1  completion pulse`
- `c_instruction_read / c_mem_read / c_mem_write  output  1 each  one-hot command strobes to cache`
- `c_addr / c_size / c_wdata  output  ADDR_WIDTH / 4 / DATA_WIDTH  command payload`
- `c_busy  input  1  cache busy`
- `c_rdata  input  DATA_WIDTH  cache read data, valid on the cycle c_busy falls`
- `timeout  output  1  one-cycle pulse when ACK_TIMEOUT expires`

## Operation
- States: IDLE, ISSUE, ACK, BUSY, RESP.
- IDLE: if any request is high and `c_busy`=0, select a winner by round-robin starting at pointer `ptr` (order I→DR→DW→I). Latch the winner ID, `c_addr`, `c_size` (fetch uses 4) and `c_wdata` (0 unless write). Go to ISSUE.
- ISSUE: exactly one command strobe is high for this single cycle. Go to ACK and clear the timeout counter.
- ACK:
  - `c_busy`=1 → BUSY.
  - Counter reaches `ACK_TIMEOUT` → capture `c_rdata`, pulse `timeout`, go to RESP.
- BUSY: on `c_busy`=0, capture `c_rdata` and go to RESP.
- RESP: pulse the winner's `*_done` and drive the captured data. Set `ptr` to winner+1 (mod 3). Return to IDLE.
- Payload outputs stay stable from ISSUE through RESP. Strobes are 0 in every state except ISSUE.
- A request dropped before grant is ignored. Dropping it after grant does not abort the access, and `done` still pulses.
- Read data outputs hold their last captured value between accesses. `dw_done` has no data.

## Timing
- Reset (async, `reset`=0): state=IDLE, `ptr`=I, and all outputs are 0, including data and payload registers.
- All outputs are registered; there are no combinational input→output paths.
- Minimum latency (cache busy for one cycle):
  - Request high in IDLE at cycle 0 → strobe at cycle 1.
  - `c_busy`=1 at cycle 2, 0 at cycle 3.
  - `*_done` at cycle 4.
- Back-to-back: IDLE is revisited for one cycle after RESP, giving a throughput of one access per 5+ cycles.
- Simultaneous requests: with `ptr`=I all three pending, the grant order is I, DR, DW.
- `c_busy`=1 in IDLE blocks any grant.
- Reset asserted mid-access: immediate return to IDLE, and no `done` is issued for the aborted access.

## Structure
- Shared package `mem_arb_pkg`:
  - `req_id_t` enum (REQ_IFETCH=0, REQ_DREAD=1, REQ_DWRITE=2).
  - `arb_state_t` enum (the five states).
  - Constant `IFETCH_SIZE`=4.
- Sub-module `rr_pick3`: combinational 3-way round-robin picker. Inputs are the request vector and pointer; outputs are the grant ID and a `valid` bit.
- Top of `mem_arbiter`: the FSM, payload and data registers, and the timeout counter.

## Test plan
- Single fetch: `i_addr`=0x1000, cache busy for cycles 2–4 with `c_rdata`=0x00000013 → `c_instruction_read` at cycle 1 only with `c_addr`=0x1000 and `c_size`=4; `i_done`=1 with `i_rdata`=0x13 at cycle 6.
- All three requesting continuously from reset:
  - Grant order is I, DR, DW, I.
  - Each `done` pulses exactly once per access.
  - At most one strobe is ever high.
- Write: `dw_addr`=0x2008, `dw_wdata`=0xDEADBEEF, `dw_size`=8 → `c_mem_write` with that payload, held stable through RESP; `dw_done` pulses; `i_done`/`dr_done` stay 0.
- No-busy cache (`c_busy` never rises), `ACK_TIMEOUT`=8 → `timeout` and `dr_done` both pulse 10 cycles after the strobe.
- Reset pulled low while in BUSY → all outputs 0 asynchronously, no `done`. After release with `i_req` high, a fresh grant goes to I.
- `c_busy` held high in IDLE while `dr_req`=1 → no strobe until `c_busy`=0, then strobe on the next cycle.
